// File: rtl/mips_ctrl_pkg.sv
// Shared types and defaults for the MIPS pipeline hazard controller.
package mips_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         FLUSH_CYCLES_DEF = 1;
  localparam int         MEM_TIMEOUT_DEF  = 255;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the EX load and the ID instruction.
module load_use_detect
  import mips_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       lu_hazard
);
  // $0 is hardwired, so a load targeting it never produces a value to wait on.
  assign lu_hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Optional HAZARD_PERF_EN adds saturating stall/flush/wait event counters.
module hazard_controller
  import mips_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int TO_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_bubble,
  output logic       ex_mem_write,
  output logic       mem_wb_bubble,
  output logic       mem_error,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] wait_count
`endif
);
  localparam logic [2:0]      FC_M1   = 3'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  ctrl_state_t     state, state_n;
  logic [2:0]      flush_cnt, flush_cnt_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            lu_hazard, lu_stall, freeze, err_set;

  load_use_detect u_lud (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .lu_hazard   (lu_hazard)
  );

  // Once in MEM_WAIT the freeze depends only on mem_ready; mem_req is not re-qualified.
  assign freeze = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    state_n       = state;
    flush_cnt_n   = flush_cnt;
    to_cnt_n      = to_cnt;
    err_set       = 1'b0;
    lu_stall      = 1'b0;
    if (reset) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
      state_n       = RUN;
      flush_cnt_n   = '0;
      to_cnt_n      = '0;
    end else if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
      if (state == MEM_WAIT) begin
        if (to_cnt == TO_LAST) begin
          err_set  = 1'b1;
          state_n  = RUN;
          to_cnt_n = '0;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end else if (state == RUN) begin
        state_n = MEM_WAIT;
      end
      // A freeze inside FLUSH holds the remaining flush count until memory is ready.
    end else begin
      to_cnt_n = '0;
      if (state == FLUSH) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (flush_cnt <= 3'd1) begin
          state_n     = RUN;
          flush_cnt_n = '0;
        end else begin
          flush_cnt_n = flush_cnt - 3'd1;
        end
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_n     = FLUSH;
          flush_cnt_n = FC_M1;
        end else begin
          state_n = RUN;
        end
      end else begin
        state_n = RUN;
        if (lu_hazard) begin
          lu_stall     = 1'b1;
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= '0;
      to_cnt    <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      to_cnt    <= to_cnt_n;
      if (err_set) mem_error <= 1'b1;
    end
  end

  assign ctrl_state = state;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
      wait_count  <= '0;
    end else begin
      if (lu_stall    && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + 32'd1;
      if (freeze      && (wait_count  != '1)) wait_count  <= wait_count  + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_hazard_controller;
  import mips_ctrl_pkg::*;

  // Output vector order: pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, mem_wb_bubble
  localparam logic [6:0] RUN_O   = 7'b1101010;
  localparam logic [6:0] RST_O   = 7'b1111111;
  localparam logic [6:0] STALL_O = 7'b0001110;
  localparam logic [6:0] FLUSH_O = 7'b1111110;
  localparam logic [6:0] FRZ_O   = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic       ex_mem_write, mem_wb_bubble, mem_error;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count, wait_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  hazard_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .TO_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_error       (mem_error),
    .ctrl_state      (ctrl_state)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .wait_count      (wait_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Check combinational outputs and registered state for the current inputs, then advance a cycle.
  task automatic cyc(input string tag, input logic [6:0] exp_o, input logic [1:0] exp_st,
                     input logic exp_err);
    #1;
    chk({tag, ".outs"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_write,
                             id_ex_bubble, ex_mem_write, mem_wb_bubble}), 32'(exp_o));
    chk({tag, ".state"}, 32'(ctrl_state), 32'(exp_st));
    chk({tag, ".err"}, 32'(mem_error), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    chk("rst0.outs", 32'({pc_write, if_id_write, if_id_flush, id_ex_write,
                          id_ex_bubble, ex_mem_write, mem_wb_bubble}), 32'(RST_O));
    @(posedge clk); #1;
    cyc("rst1", RST_O, 2'd0, 1'b0);
    reset = 1'b0;
    cyc("run_idle", RUN_O, 2'd0, 1'b0);

    // load-use on rs, then on rt (only when rt is read), then $0
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    cyc("lu_rs", STALL_O, 2'd0, 1'b0);
    idle();
    cyc("lu_after", RUN_O, 2'd0, 1'b0);
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    cyc("lu_rt_unused", RUN_O, 2'd0, 1'b0);
    id_uses_rt = 1'b1;
    cyc("lu_rt_used", STALL_O, 2'd0, 1'b0);
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    cyc("lu_r0", RUN_O, 2'd0, 1'b0);
    idle();

    // branch flush: two cycles, taken/load-use inside FLUSH ignored
    ex_branch_taken = 1'b1;
    cyc("br_c1", FLUSH_O, 2'd0, 1'b0);
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    cyc("br_c2", FLUSH_O, 2'd1, 1'b0);
    idle();
    cyc("br_done", RUN_O, 2'd0, 1'b0);

    // branch and load-use together: flush wins
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    cyc("brlu_c1", FLUSH_O, 2'd0, 1'b0);
    idle();
    cyc("brlu_c2", FLUSH_O, 2'd1, 1'b0);
    cyc("brlu_done", RUN_O, 2'd0, 1'b0);

    // memory wait, 3 frozen cycles; load-use pending is serviced on the ready cycle
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("mw_c1", FRZ_O, 2'd0, 1'b0);
    cyc("mw_c2", FRZ_O, 2'd2, 1'b0);
    ex_mem_read = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
    cyc("mw_c3", FRZ_O, 2'd2, 1'b0);
    mem_ready = 1'b1;
    cyc("mw_ready", STALL_O, 2'd2, 1'b0);
    idle();
    cyc("mw_done", RUN_O, 2'd0, 1'b0);

    // timeout after the 4th MEM_WAIT cycle
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("to_enter", FRZ_O, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc($sformatf("to_w%0d", i + 1), FRZ_O, 2'd2, 1'b0);
    idle();
    cyc("to_err", RUN_O, 2'd0, 1'b1);
    cyc("to_sticky", RUN_O, 2'd0, 1'b1);

`ifdef HAZARD_PERF_EN
    chk("perf_stall", stall_count, 32'd3);
    chk("perf_flush", flush_count, 32'd4);
    chk("perf_wait", wait_count, 32'd8);
`endif

    // reset in the middle of a memory wait
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("rmw_c1", FRZ_O, 2'd0, 1'b1);
    cyc("rmw_c2", FRZ_O, 2'd2, 1'b1);
    reset = 1'b1;
    cyc("rmw_rst", RST_O, 2'd2, 1'b1);
    reset = 1'b0; idle();
    cyc("rmw_after", RUN_O, 2'd0, 1'b0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_clr", stall_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
endmodule
